// File: rtl/ps2_num_display.sv
// Captures three BCD digits from the PS/2 receiver, validates them, converts them to binary and scans a 4-digit 7-segment display.
// Latency: digits, count and error flag update at the capture edge; oValue/oValid and oSeg follow one edge later.
// Backpressure: none; every iNumRdy pulse is processed, including pulses on consecutive cycles.
module ps2_num_display #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [3:0] iNum1,
   input  logic [3:0] iNum2,
   input  logic [3:0] iNum3,
   input  logic       iNumRdy,
   output logic [6:0] oSeg,
   output logic [3:0] oAn,
   output logic [9:0] oValue,
   output logic       oValid,
   output logic       oErr
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   logic [3:0]    h_q, t_q, o_q, c_q;
   logic          err_q;
   logic          have_q;
   logic [CW-1:0] scan_cnt;
   logic [1:0]    idx;
   logic          digits_ok;
   logic          accept;
   logic          reject;
   logic [9:0]    value_c;
   logic [6:0]    seg_next;

   // Segment pattern for one BCD digit; anything above 9 renders blank.
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'h40;
         4'd1:    seg_of = 7'h79;
         4'd2:    seg_of = 7'h24;
         4'd3:    seg_of = 7'h30;
         4'd4:    seg_of = 7'h19;
         4'd5:    seg_of = 7'h12;
         4'd6:    seg_of = 7'h02;
         4'd7:    seg_of = 7'h78;
         4'd8:    seg_of = 7'h00;
         4'd9:    seg_of = 7'h10;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

   assign digits_ok = (iNum1 <= 4'd9) && (iNum2 <= 4'd9) && (iNum3 <= 4'd9);
   assign accept    = iNumRdy && digits_ok;
   assign reject    = iNumRdy && !digits_ok;

   // Capture stage: load digits and bump the entry count on accept, flag errors on reject.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         h_q    <= '0;
         t_q    <= '0;
         o_q    <= '0;
         c_q    <= '0;
         err_q  <= 1'b0;
         have_q <= 1'b0;
      end else if (accept) begin
         h_q    <= iNum1;
         t_q    <= iNum2;
         o_q    <= iNum3;
         c_q    <= (c_q == 4'd9) ? 4'd0 : c_q + 4'd1;
         err_q  <= 1'b0;
         have_q <= 1'b1;
      end else if (reject) begin
         err_q  <= 1'b1;
         have_q <= 1'b0;
      end
   end

   assign oErr = err_q;

   // Max 999 fits in 10 bits, so the sum never overflows.
   assign value_c = 10'(h_q) * 10'd100 + 10'(t_q) * 10'd10 + 10'(o_q);

   // Conversion stage: one register after capture.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         oValue <= '0;
         oValid <= 1'b0;
      end else begin
         oValue <= value_c;
         oValid <= have_q;
      end
   end

   // Scan timer: each digit index holds for SCAN_DIV cycles; captures never disturb it.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         idx      <= idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Pick the segment pattern for the current index, with leading-zero blanking and error dashes.
   always_comb begin
      seg_next = SEG_BLANK;
      case (idx)
         2'd0: seg_next = err_q ? SEG_DASH : seg_of(o_q);
         2'd1: seg_next = err_q ? SEG_DASH :
                          ((h_q == 4'd0) && (t_q == 4'd0)) ? SEG_BLANK : seg_of(t_q);
         2'd2: seg_next = err_q ? SEG_DASH :
                          (h_q == 4'd0) ? SEG_BLANK : seg_of(h_q);
         default: seg_next = seg_of(c_q);
      endcase
   end

   // Registered display drive: exactly one anode low at a time.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         oSeg <= SEG_BLANK;
         oAn  <= 4'hF;
      end else begin
         oSeg <= seg_next;
         oAn  <= ~(4'b0001 << idx);
      end
   end

endmodule

// File: tb/tb_ps2_num_display.sv
// Directed bench for ps2_num_display with a short scan period.
// Latency: checks capture-edge and one-edge-later outputs explicitly.
// Backpressure: none; back-to-back pulses are exercised.
module tb_ps2_num_display;

   logic       CLK;
   logic       reset;
   logic [3:0] iNum1, iNum2, iNum3;
   logic       iNumRdy;
   logic [6:0] oSeg;
   logic [3:0] oAn;
   logic [9:0] oValue;
   logic       oValid;
   logic       oErr;

   int errors;
   int checks;
   int ecnt;

   ps2_num_display #(.SCAN_DIV(4)) dut (
      .CLK(CLK), .reset(reset),
      .iNum1(iNum1), .iNum2(iNum2), .iNum3(iNum3), .iNumRdy(iNumRdy),
      .oSeg(oSeg), .oAn(oAn), .oValue(oValue), .oValid(oValid), .oErr(oErr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Edges since reset released; used to predict the scan index.
   always @(posedge CLK or posedge reset) begin
      if (reset) ecnt <= 0;
      else       ecnt <= ecnt + 1;
   end

   task automatic test_reset;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      checks++;
      if (oSeg !== 7'h7F || oAn !== 4'hF || oValue !== 10'd0 || oValid !== 1'b0 || oErr !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: seg=%h an=%b value=%0d valid=%b err=%b, want 7f 1111 0 0 0",
                  oSeg, oAn, oValue, oValid, oErr);
      end
      @(negedge CLK);
      @(negedge CLK);
      reset = 1'b0;
   endtask

   task automatic test_idle_scan;
      logic [6:0] exp_seg [4];
      logic [3:0] exp_an;
      int         idx;
      exp_seg[0] = 7'h40; exp_seg[1] = 7'h7F; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h40;
      for (int k = 0; k < 16; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         idx    = ((ecnt - 1) / 4) % 4;
         exp_an = ~(4'b0001 << idx);
         checks++;
         if (oSeg !== exp_seg[idx] || oAn !== exp_an) begin
            errors++;
            $display("FAIL idle_scan cyc%0d: seg=%h an=%b, want %h %b", k, oSeg, oAn, exp_seg[idx], exp_an);
         end
      end
      checks++;
      if (oValid !== 1'b0) begin
         errors++;
         $display("FAIL idle_valid: valid=%b, want 0", oValid);
      end
   endtask

   task automatic test_accept_307;
      logic [6:0] exp_seg [4];
      logic [3:0] exp_an;
      int         idx;
      @(negedge CLK);
      iNum1 = 4'd3; iNum2 = 4'd0; iNum3 = 4'd7; iNumRdy = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      iNumRdy = 1'b0;
      checks++;
      if (oValid !== 1'b0 || oErr !== 1'b0) begin
         errors++;
         $display("FAIL accept307_edgeN: valid=%b err=%b, want 0 0", oValid, oErr);
      end
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (oValue !== 10'd307 || oValid !== 1'b1) begin
         errors++;
         $display("FAIL accept307_value: value=%0d valid=%b, want 307 1", oValue, oValid);
      end
      exp_seg[0] = 7'h78; exp_seg[1] = 7'h40; exp_seg[2] = 7'h30; exp_seg[3] = 7'h79;
      for (int k = 0; k < 16; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         idx    = ((ecnt - 1) / 4) % 4;
         exp_an = ~(4'b0001 << idx);
         checks++;
         if (oSeg !== exp_seg[idx] || oAn !== exp_an) begin
            errors++;
            $display("FAIL scan_307 cyc%0d: seg=%h an=%b, want %h %b", k, oSeg, oAn, exp_seg[idx], exp_an);
         end
      end
   endtask

   task automatic test_blanking_005;
      logic [6:0] exp_seg [4];
      int         idx;
      @(negedge CLK);
      iNum1 = 4'd0; iNum2 = 4'd0; iNum3 = 4'd5; iNumRdy = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      iNumRdy = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (oValue !== 10'd5 || oValid !== 1'b1) begin
         errors++;
         $display("FAIL accept005_value: value=%0d valid=%b, want 5 1", oValue, oValid);
      end
      exp_seg[0] = 7'h12; exp_seg[1] = 7'h7F; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h24;
      for (int k = 0; k < 16; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         idx = ((ecnt - 1) / 4) % 4;
         checks++;
         if (oSeg !== exp_seg[idx]) begin
            errors++;
            $display("FAIL scan_005 cyc%0d idx%0d: seg=%h, want %h", k, idx, oSeg, exp_seg[idx]);
         end
      end
   endtask

   task automatic test_reject;
      logic [6:0] exp_seg [4];
      int         idx;
      @(negedge CLK);
      iNum1 = 4'd3; iNum2 = 4'd0; iNum3 = 4'd7; iNumRdy = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      iNum1 = 4'd1; iNum2 = 4'hA; iNum3 = 4'd2; iNumRdy = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      iNumRdy = 1'b0;
      checks++;
      if (oErr !== 1'b1) begin
         errors++;
         $display("FAIL reject_err_edgeN: err=%b, want 1", oErr);
      end
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (oValid !== 1'b0 || oValue !== 10'd307) begin
         errors++;
         $display("FAIL reject_valid: valid=%b value=%0d, want 0 307", oValid, oValue);
      end
      exp_seg[0] = 7'h3F; exp_seg[1] = 7'h3F; exp_seg[2] = 7'h3F; exp_seg[3] = 7'h30;
      for (int k = 0; k < 16; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         idx = ((ecnt - 1) / 4) % 4;
         checks++;
         if (oSeg !== exp_seg[idx]) begin
            errors++;
            $display("FAIL scan_err cyc%0d idx%0d: seg=%h, want %h", k, idx, oSeg, exp_seg[idx]);
         end
      end
      @(negedge CLK);
      iNum1 = 4'd9; iNum2 = 4'd9; iNum3 = 4'd9; iNumRdy = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      iNumRdy = 1'b0;
      checks++;
      if (oErr !== 1'b0) begin
         errors++;
         $display("FAIL recover_err: err=%b, want 0", oErr);
      end
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (oValue !== 10'd999 || oValid !== 1'b1) begin
         errors++;
         $display("FAIL recover_value: value=%0d valid=%b, want 999 1", oValue, oValid);
      end
   endtask

   task automatic test_reset_mid;
      @(posedge CLK);
      @(posedge CLK);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (oSeg !== 7'h7F || oAn !== 4'hF || oValue !== 10'd0 || oValid !== 1'b0 || oErr !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: seg=%h an=%b value=%0d valid=%b err=%b, want 7f 1111 0 0 0",
                  oSeg, oAn, oValue, oValid, oErr);
      end
      @(negedge CLK);
      reset = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [9:0] val [10];
      logic [6:0] exp_seg [4];
      int         idx;
      for (int i = 0; i < 10; i++)
         val[i] = 10'(100 * i + 10 * ((i + 3) % 10) + (9 - i));
      for (int i = 0; i < 10; i++) begin
         iNum1 = 4'(i); iNum2 = 4'((i + 3) % 10); iNum3 = 4'(9 - i); iNumRdy = 1'b1;
         @(posedge CLK);
         @(negedge CLK);
         if (i > 0) begin
            checks++;
            if (oValue !== val[i-1] || oValid !== 1'b1) begin
               errors++;
               $display("FAIL b2b_entry%0d: value=%0d valid=%b, want %0d 1", i - 1, oValue, oValid, val[i-1]);
            end
         end
      end
      iNumRdy = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (oValue !== val[9] || oValid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_last: value=%0d valid=%b, want %0d 1", oValue, oValid, val[9]);
      end
      // Last entry 9/2/0; count wrapped to 0.
      exp_seg[0] = 7'h40; exp_seg[1] = 7'h24; exp_seg[2] = 7'h10; exp_seg[3] = 7'h40;
      for (int k = 0; k < 16; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         idx = ((ecnt - 1) / 4) % 4;
         checks++;
         if (oSeg !== exp_seg[idx]) begin
            errors++;
            $display("FAIL scan_wrap cyc%0d idx%0d: seg=%h, want %h", k, idx, oSeg, exp_seg[idx]);
         end
      end
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      iNum1   = 4'd0;
      iNum2   = 4'd0;
      iNum3   = 4'd0;
      iNumRdy = 1'b0;
      test_reset();
      test_idle_scan();
      test_accept_307();
      test_blanking_005();
      test_reject();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_num_display.md
# ps2_num_display

Display and value stage fed by the PS/2 keyboard receiver. It captures the three decoded BCD digits when the receiver's ready pulse arrives and validates them. It converts the accepted number to binary for downstream logic. It time-multiplexes a 4-digit common-anode 7-segment display: three digits show the number with leading-zero blanking, and the leftmost digit shows the count of accepted entries.

## Interface
- SCAN_DIV, 50000: CLK cycles each digit stays lit; legal range ≥ 2.
- CLK  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- iNum1  input  4  hundreds digit (BCD).
- iNum2  input  4  tens digit (BCD).
- iNum3  input  4  ones digit (BCD).
- iNumRdy  input  1  one-cycle pulse; iNum1..3 valid in the same cycle.
- oSeg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- oAn  output  4  digit enables, active-low; bit 0 = rightmost digit.
- oValue  output  10  binary value of the last accepted number, 0–999.
- oValid  output  1  high while oValue holds an accepted number.
- oErr  output  1  high after a rejected capture, until the next accepted one.

## Operation
- Capture: on iNumRdy, the entry is accepted when all of iNum1..3 ≤ 9 and rejected otherwise.
  - Accept: load digit registers H, T, O; increment entry count C (0–9, 9 wraps to 0); clear the error flag.
  - Reject: H, T, O and C unchanged; set the error flag; oValid is forced to 0.
- Conversion, pipelined one stage after capture: oValue = 100·H + 10·T + O, computed at 10 bits with no overflow possible.
  - oValid rises with the first accepted entry. It stays high until a reject or reset.
- iNumRdy may arrive on consecutive cycles. Each pulse is processed independently, with no pulse dropped.
- Scan counter: counts 0..SCAN_DIV-1. On wrap, digit index advances 0→1→2→3→0.
- Digit content by index:
  - 0 (ones): O, always shown.
  - 1 (tens): T; blank when H=0 and T=0.
  - 2 (hundreds): H; blank when H=0.
  - 3: C, always shown.
- While the error flag is set, indices 0–2 show a dash and index 3 still shows C.
- Segment codes, hex, bit6 = g:
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Blank = 7F; dash = 3F.
- Only one oAn bit is low at a time: oAn = ~(4'b0001 << index).

## Timing
- Reset values:
  - oSeg=7'h7F, oAn=4'hF, oValue=0, oValid=0, oErr=0.
  - H=T=O=0, C=0, index=0, scan counter=0.
- oSeg and oAn are registered. On the first edge after reset deasserts: oAn=4'b1110 and oSeg=40, showing ones digit 0.
- Latency from iNumRdy sampled at edge N:
  - H/T/O/C and the error flag update at edge N.
  - oErr changes at edge N.
  - oValue and oValid change at edge N+1.
  - oSeg reflects the new digits from edge N+1.
- Each digit is lit for exactly SCAN_DIV cycles. A full frame is 4·SCAN_DIV cycles.
- Capturing a digit does not reset the scan counter or the index.
- Reset asserted mid-scan or mid-pipeline: all outputs go to their reset values asynchronously. No partial capture survives.

## Test plan
- Reset, then idle with SCAN_DIV=4:
  - oAn cycles 1110→1101→1011→0111, 4 cycles each.
  - oSeg shows 40, 7F, 7F, 40 respectively.
  - oValid=0.
- iNumRdy with 3/0/7 → oValue=307 and oValid=1 two edges after the pulse. Scan shows 78, 40, 30, 79 (C=1).
- iNumRdy with 0/0/5 → hundreds and tens blank (7F), ones 12; oValue=5.
- iNumRdy with 1/A/2 after a valid 307:
  - oErr=1 and oValid=0.
  - Indices 0–2 show 3F; C unchanged.
  - A following valid 9/9/9 clears oErr and gives oValue=999.
- Ten accepted entries in back-to-back cycles → C wraps to 0. oValue equals the last entry one edge after its capture.
- reset asserted mid-digit with an entry present → oSeg=7F, oAn=F, oValue=0, and oValid=0 with no clock edge needed.
